bus_source_arbiter: RTL and testbench

//  Upstream control stage for the 32-to-1 internal bus multiplexer.
//  - Takes one "drive bus" request per datapath source (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, ...).
//  - Grants the bus round-robin to one source at a time.
//  - Drives the registered 5-bit select code and the enable strobe for the mux.
//  - Enable drops low for one cycle between grants, so the mux always sees a fresh enable edge.

---
 rtl/bus_source_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_source_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bus_source_arbiter
// Purpose : Round-robin arbiter driving the select/enable of the 32:1 bus mux,
//           with a one-cycle enable gap between grants and hold-time preemption.
//           Optional macro BUS_ARB_CONFLICT_DET_EN adds idle-bus race detection.
// Revision: 1.0 - initial release
// ============================================================================
module bus_source_arbiter #(
  parameter int N_SRC    = 32,
  parameter int SEL_W    = 5,
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] out_req,
  output logic [SEL_W-1:0] select,
  output logic             enable,
  output logic [N_SRC-1:0] grant,
  output logic             busy,
  output logic             timeout_err
`ifdef BUS_ARB_CONFLICT_DET_EN
  ,
  output logic             conflict,
  output logic [7:0]       conflict_cnt
`endif
);

  localparam int c_HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [c_HC_W-1:0] c_HOLD_LAST = c_HC_W'(HOLD_MAX - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT = 2'd1;
  localparam logic [1:0] c_GAP   = 2'd2;

  logic [1:0]        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_rr_ptr;
  logic              r_en;
  logic              r_busy;
  logic              r_tout;
  logic [N_SRC-1:0]  r_grant;
  logic [c_HC_W-1:0] r_hold_cnt;

  logic              w_any_req;
  logic              w_found;
  logic              w_owner_req;
  logic              w_others;
  logic              w_hold_last;
  logic [SEL_W-1:0]  w_winner;

  // Search starts just after the last owner; i == N_SRC wraps back to the
  // last owner itself, giving it the lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      if (!w_found && out_req[r_rr_ptr + SEL_W'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_rr_ptr + SEL_W'(i);
      end
    end
  end

  assign w_any_req   = |out_req;
  assign w_owner_req = out_req[r_sel];
  assign w_others    = |(out_req & ~r_grant);
  assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= c_IDLE;
      r_sel      <= '0;
      r_rr_ptr   <= '1;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_tout     <= 1'b0;
      r_grant    <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_tout <= 1'b0;
      case (r_state)
        c_GRANT: begin
          if (!w_owner_req || (w_hold_last && w_others)) begin
            r_state <= c_GAP;
            r_en    <= 1'b0;
            r_grant <= '0;
            // A voluntary release wins over a coincident hold-limit hit.
            r_tout  <= w_owner_req;
          end else if (!w_hold_last) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          if (w_any_req) begin
            r_state    <= c_GRANT;
            r_sel      <= w_winner;
            r_rr_ptr   <= w_winner;
            r_en       <= 1'b1;
            r_busy     <= 1'b1;
            r_grant    <= {{(N_SRC-1){1'b0}}, 1'b1} << w_winner;
            r_hold_cnt <= '0;
          end else begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign select      = r_sel;
  assign enable      = r_en;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_tout;

`ifdef BUS_ARB_CONFLICT_DET_EN
  logic       r_conflict;
  logic [7:0] r_conflict_cnt;
  logic       w_multi_req;

  assign w_multi_req = |(out_req & (out_req - N_SRC'(1)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_conflict     <= 1'b0;
      r_conflict_cnt <= '0;
    end else if (r_state == c_IDLE && w_multi_req) begin
      r_conflict <= 1'b1;
      if (r_conflict_cnt != 8'hFF) begin
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end
    end
  end

  assign conflict     = r_conflict;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_source_arbiter
// Purpose : Directed vector-table bench for bus_source_arbiter (HOLD_MAX=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_source_arbiter;

  typedef struct {
    logic        rst_before;
    logic [31:0] req;
    logic [4:0]  sel;
    logic        en;
    logic [31:0] gnt;
    logic        busy;
    logic        tout;
  } vec_t;

  logic        clk;
  logic        clr;
  logic [31:0] out_req;
  logic [4:0]  select;
  logic        enable;
  logic [31:0] grant;
  logic        busy;
  logic        timeout_err;
`ifdef BUS_ARB_CONFLICT_DET_EN
  logic        conflict;
  logic [7:0]  conflict_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  bus_source_arbiter #(.N_SRC(32), .SEL_W(5), .HOLD_MAX(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .out_req     (out_req),
    .select      (select),
    .enable      (enable),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef BUS_ARB_CONFLICT_DET_EN
    ,
    .conflict    (conflict),
    .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rb, input logic [31:0] req, input logic [4:0] sel,
                     input logic en, input logic [31:0] gnt, input logic bsy, input logic to);
    vec_t v;
    v.rst_before = rb; v.req = req; v.sel = sel; v.en = en;
    v.gnt = gnt; v.busy = bsy; v.tout = to;
    vq.push_back(v);
  endtask

  task automatic step(input logic [31:0] req);
    @(negedge clk);
    out_req = req;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    // single request, release, gap, idle
    add(0, 32'h0000_0020, 5'd5,  1, 32'h0000_0020, 1, 0);
    add(0, 32'h0000_0000, 5'd5,  0, 32'h0000_0000, 1, 0);
    add(0, 32'h0000_0000, 5'd5,  0, 32'h0000_0000, 0, 0);
    // round robin between 3 and 7, starting from reset pointer
    add(1, 32'h0000_0088, 5'd3,  1, 32'h0000_0008, 1, 0);
    add(0, 32'h0000_0088, 5'd3,  1, 32'h0000_0008, 1, 0);
    add(0, 32'h0000_0080, 5'd3,  0, 32'h0000_0000, 1, 0);
    add(0, 32'h0000_0080, 5'd7,  1, 32'h0000_0080, 1, 0);
    add(0, 32'h0000_0088, 5'd7,  1, 32'h0000_0080, 1, 0);
    add(0, 32'h0000_0008, 5'd7,  0, 32'h0000_0000, 1, 0);
    add(0, 32'h0000_0008, 5'd3,  1, 32'h0000_0008, 1, 0);
    add(0, 32'h0000_0000, 5'd3,  0, 32'h0000_0000, 1, 0);
    add(0, 32'h0000_0000, 5'd3,  0, 32'h0000_0000, 0, 0);
    // preemption after 4 grant cycles
    add(0, 32'h0000_0004, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  0, 32'h0000_0000, 1, 1);
    add(0, 32'h0000_0204, 5'd9,  1, 32'h0000_0200, 1, 0);
    add(0, 32'h0000_0004, 5'd9,  0, 32'h0000_0000, 1, 0);
    // release coinciding with hold limit: no timeout
    add(0, 32'h0000_0004, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0204, 5'd2,  1, 32'h0000_0004, 1, 0);
    add(0, 32'h0000_0200, 5'd2,  0, 32'h0000_0000, 1, 0);
    add(0, 32'h0000_0200, 5'd9,  1, 32'h0000_0200, 1, 0);
    add(0, 32'h0000_0000, 5'd9,  0, 32'h0000_0000, 1, 0);
    add(0, 32'h0000_0000, 5'd9,  0, 32'h0000_0000, 0, 0);
    // lone owner saturates hold count without preemption, then wrap 31 -> 0
    add(0, 32'h8000_0000, 5'd31, 1, 32'h8000_0000, 1, 0);
    add(0, 32'h8000_0000, 5'd31, 1, 32'h8000_0000, 1, 0);
    add(0, 32'h8000_0000, 5'd31, 1, 32'h8000_0000, 1, 0);
    add(0, 32'h8000_0000, 5'd31, 1, 32'h8000_0000, 1, 0);
    add(0, 32'h8000_0000, 5'd31, 1, 32'h8000_0000, 1, 0);
    add(0, 32'h4000_0001, 5'd31, 0, 32'h0000_0000, 1, 0);
    add(0, 32'h4000_0001, 5'd0,  1, 32'h0000_0001, 1, 0);

    clr = 1'b1;
    out_req = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset select", 32'(select), 32'd0);
    check("reset enable", 32'(enable), 32'd0);
    check("reset grant",  grant,       32'd0);
    check("reset busy",   32'(busy),   32'd0);
    check("reset tout",   32'(timeout_err), 32'd0);
`ifdef BUS_ARB_CONFLICT_DET_EN
    check("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
    @(negedge clk);
    out_req = '0;
    clr = 1'b0;
    step('0);
    check("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      if (v.rst_before) begin
        clr = 1'b1;
        #1;
        clr = 1'b0;
      end
      out_req = v.req;
      @(posedge clk);
      #1;
      check($sformatf("row%0d select", i), 32'(select),      32'(v.sel));
      check($sformatf("row%0d enable", i), 32'(enable),      32'(v.en));
      check($sformatf("row%0d grant",  i), grant,            v.gnt);
      check($sformatf("row%0d busy",   i), 32'(busy),        32'(v.busy));
      check($sformatf("row%0d tout",   i), 32'(timeout_err), 32'(v.tout));
    end

    // asynchronous clear mid-grant, no clock edge involved
    @(negedge clk);
    #1;
    clr = 1'b1;
    #1;
    check("async clr enable", 32'(enable), 32'd0);
    check("async clr grant",  grant,       32'd0);
    check("async clr select", 32'(select), 32'd0);
    check("async clr busy",   32'(busy),   32'd0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check("restart select", 32'(select), 32'd0);
    check("restart grant",  grant,       32'd1);
    step('0);
    step('0);

`ifdef BUS_ARB_CONFLICT_DET_EN
    @(negedge clk);
    clr = 1'b1;
    #1;
    clr = 1'b0;
    step(32'h0000_0012);
    check("conflict flag",      32'(conflict),     32'd1);
    check("conflict_cnt first", 32'(conflict_cnt), 32'd1);
    check("conflict grant",     grant,             32'h0000_0002);
    for (int k = 0; k < 300; k++) begin
      step('0);
      step('0);
      step(32'h0000_0012);
    end
    check("conflict_cnt sat",  32'(conflict_cnt), 32'd255);
    check("conflict sticky",   32'(conflict),     32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
